univ_reg: RTL and testbench
===========================

# univ_reg

Parametrised universal register: generalises the single-bit D and SR flip-flops to a WIDTH-bit register with async active-low reset, synchronous clear/set (clear wins), a global enable, and a per-cycle operation select (hold, load, shift, rotate, increment, decrement). It is the common storage/shift/count primitive for datapath blocks. Every output is registered.

## Interface
Parameters:
- WIDTH, 8, register width in bits; must be ≥ 2.
- RST_VAL, '0, value loaded by async reset; WIDTH bits.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear: q←0; highest synchronous priority.
- set  in  1  synchronous set: q←all ones; ignored when clr=1.
- en  in  1  operation enable; en=0 holds q, co and zero.
- op  in  3  operation select, type op_t.
- d  in  WIDTH  parallel load data.
- sin  in  1  serial input for SHL/SHR.
- q  out  WIDTH  register contents.
- co  out  1  registered carry/shift-out of the last executed operation.
- zero  out  1  registered flag: 1 iff q == 0, always consistent with q.

## Operation
- Per-cycle priority: rst_n=0 (async), then clr, then set, then en=0 (hold all), then op.
- clr: q←0, co←0, zero←1.
- set: q←'1, co←0, zero←0.
- op_t encodings:
  - HOLD=0: q, co unchanged.
  - LOAD=1: q←d; co←0.
  - SHL=2: q←{q[W-2:0],sin}; co←q[W-1].
  - SHR=3: q←{sin,q[W-1:1]}; co←q[0].
  - ROL=4: q←{q[W-2:0],q[W-1]}; co←q[W-1].
  - ROR=5: q←{q[0],q[W-1:1]}; co←q[0].
  - INC=6: {co,q}←q+1 (WIDTH+1-bit sum); wraps all-ones→0 with co=1.
  - DEC=7: q←q−1 mod 2^WIDTH; co←1 iff q was 0 (borrow); wraps 0→all-ones.
- zero is computed from the next-state value and registered with q; it is never one cycle stale.
- Unknown/X op: treated as HOLD.

## Timing
- Async reset: on rst_n falling, q←RST_VAL, co←0, zero←(RST_VAL==0) immediately, without waiting for clk. Held while rst_n=0; the first operation occurs on the first posedge after rst_n rises.
- Reset mid-operation: in-flight shift or count is discarded; no partial update.
- Latency: every operation takes 1 cycle; the result is visible on q/co/zero after the capturing posedge.
- Back-to-back operations are supported each cycle with no bubbles.
- clr and set together: clr wins (q=0), whatever en and op are.
- clr/set act even when en=0.
- en=0 with op≠HOLD: no change, including co.

## Structure
- Package univ_reg_pkg: op_t enum (3-bit, encodings above) and localparam OP_W=3.
- Sub-module univ_reg_nxt: purely combinational next-state function (q, op, d, sin → q_nxt, co_nxt). univ_reg holds the priority mux, the always_ff with async reset, and the zero computation.
- No other hierarchy.

## Test plan
- Reset: RST_VAL=8'hA5, assert rst_n=0 between edges → q=A5, co=0, zero=0 before the next posedge; release, op=HOLD → q stays A5.
- Load/shift: LOAD d=8'h81 → q=81; SHL sin=0 → q=02, co=1; SHR sin=1 → q=81, co=0; ROR → q=C0, co=1.
- Count wrap: LOAD FF, INC → q=00, co=1, zero=1; DEC → q=FF, co=1, zero=0; DEC → q=FE, co=0.
- Priority: clr=1 and set=1 with op=LOAD d=55 → q=00, zero=1; set=1 only, en=0 → q=FF; en=0 with op=INC → q and co unchanged for 3 cycles.
- Reset mid-count: INC each cycle from 00; drop rst_n at q=03 → q=RST_VAL immediately; rising rst_n resumes counting from RST_VAL.
- Randomised op/d/sin/en/clr/set for 10k cycles against a reference model at WIDTH=8 and WIDTH=2.

Source files
------------

// File: rtl/univ_reg_pkg.sv
// Shared types for the universal register: operation encodings and their width.
package univ_reg_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    HOLD = 3'd0,
    LOAD = 3'd1,
    SHL  = 3'd2,
    SHR  = 3'd3,
    ROL  = 3'd4,
    ROR  = 3'd5,
    INC  = 3'd6,
    DEC  = 3'd7
  } op_t;

endpackage

// File: rtl/univ_reg_nxt.sv
// Combinational next-state function of the universal register for one op.
// co is passed in so that HOLD and undefined op codes keep it unchanged.
module univ_reg_nxt
  import univ_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic             co,
  input  op_t              op,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q_nxt,
  output logic             co_nxt
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    q_nxt  = q;
    co_nxt = co;
    case (op)
      LOAD: begin
        q_nxt  = d;
        co_nxt = 1'b0;
      end
      SHL: begin
        q_nxt  = {q[WIDTH-2:0], sin};
        co_nxt = q[WIDTH-1];
      end
      SHR: begin
        q_nxt  = {sin, q[WIDTH-1:1]};
        co_nxt = q[0];
      end
      ROL: begin
        q_nxt  = {q[WIDTH-2:0], q[WIDTH-1]};
        co_nxt = q[WIDTH-1];
      end
      ROR: begin
        q_nxt  = {q[0], q[WIDTH-1:1]};
        co_nxt = q[0];
      end
      // Carry out of a WIDTH+1-bit sum; set only on the all-ones wrap.
      INC: {co_nxt, q_nxt} = {1'b0, q} + {1'b0, ONE};
      DEC: begin
        q_nxt  = q - ONE;
        co_nxt = (q == '0);
      end
      // HOLD and any unknown code leave state untouched.
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/univ_reg.sv
// Universal WIDTH-bit register: async reset, sync clear/set, enable and op select.
// zero is derived from the value being captured so it always matches q.
module univ_reg
  import univ_reg_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             set,
  input  logic             en,
  input  op_t              op,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             co,
  output logic             zero
);

  logic [WIDTH-1:0] q_nxt;
  logic             co_nxt;
  logic [WIDTH-1:0] q_sel;
  logic             co_sel;
  logic             zero_sel;

  univ_reg_nxt #(
    .WIDTH(WIDTH)
  ) u_nxt (
    .q     (q),
    .co    (co),
    .op    (op),
    .d     (d),
    .sin   (sin),
    .q_nxt (q_nxt),
    .co_nxt(co_nxt)
  );

  // Synchronous priority: clr over set over enable-gated op.
  always_comb begin
    q_sel  = q;
    co_sel = co;
    if (clr) begin
      q_sel  = '0;
      co_sel = 1'b0;
    end else if (set) begin
      q_sel  = '1;
      co_sel = 1'b0;
    end else if (en) begin
      q_sel  = q_nxt;
      co_sel = co_nxt;
    end
  end

  assign zero_sel = (q_sel == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= RST_VAL;
      co   <= 1'b0;
      zero <= (RST_VAL == '0);
    end else begin
      q    <= q_sel;
      co   <= co_sel;
      zero <= zero_sel;
    end
  end

endmodule

// File: tb/tb_univ_reg.sv
// Bench for univ_reg: directed scenarios at WIDTH=8 plus randomised runs at WIDTH=8 and 2
// against an arithmetic reference model.
module tb_univ_reg;
  import univ_reg_pkg::*;

  localparam logic [7:0] RV8 = 8'hA5;
  localparam logic [1:0] RV2 = 2'b00;

  logic       clk;
  logic       rst_n, clr, set, en, sin;
  op_t        op;
  logic [7:0] d;
  logic [7:0] q;
  logic       co, zero;

  logic       rst2_n, clr2, set2, en2, sin2;
  op_t        op2;
  logic [1:0] d2;
  logic [1:0] q2;
  logic       co2, zero2;

  int vectors;
  int miscompares;

  univ_reg #(.WIDTH(8), .RST_VAL(RV8)) dut8 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .set(set), .en(en), .op(op),
    .d(d), .sin(sin), .q(q), .co(co), .zero(zero)
  );

  univ_reg #(.WIDTH(2), .RST_VAL(RV2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .clr(clr2), .set(set2), .en(en2), .op(op2),
    .d(d2), .sin(sin2), .q(q2), .co(co2), .zero(zero2)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs on the 8-bit instance, then sample 1 time unit after the edge.
  task automatic drive(input logic c, input logic s, input logic e, input op_t o,
                       input logic [7:0] dv, input logic si);
    clr = c; set = s; en = e; op = o; d = dv; sin = si;
    @(posedge clk);
    #1;
  endtask

  // Reference model: register contents as an integer modulo 2^w.
  task automatic model_step(input int w, input bit c, input bit s, input bit e,
                            input int opv, input int dv, input bit si,
                            inout int mq, inout bit mc);
    int m;
    int msb;
    int lsb;
    m   = 1 << w;
    msb = mq / (m / 2);
    lsb = mq % 2;
    if (c) begin
      mq = 0; mc = 0;
    end else if (s) begin
      mq = m - 1; mc = 0;
    end else if (e) begin
      case (opv)
        1: begin mq = dv; mc = 0; end
        2: begin mc = bit'(msb); mq = (mq * 2 + int'(si)) % m; end
        3: begin mc = bit'(lsb); mq = mq / 2 + int'(si) * (m / 2); end
        4: begin mc = bit'(msb); mq = (mq * 2) % m + msb; end
        5: begin mc = bit'(lsb); mq = mq / 2 + lsb * (m / 2); end
        6: begin mc = (mq == m - 1); mq = (mq + 1) % m; end
        7: begin mc = (mq == 0); mq = (mq + m - 1) % m; end
        default: begin end
      endcase
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst2_n = 1'b0;
    clr = 0; set = 0; en = 0; op = HOLD; d = '0; sin = 0;
    clr2 = 0; set2 = 0; en2 = 0; op2 = HOLD; d2 = '0; sin2 = 0;
    @(posedge clk); @(posedge clk); #1;
    vectors++;
    if ({q, co, zero} !== {RV8, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset8: q=%h co=%b zero=%b expected q=%h co=0 zero=0", q, co, zero, RV8);
    end
    vectors++;
    if ({q2, co2, zero2} !== {RV2, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset2: q=%b co=%b zero=%b expected q=%b co=0 zero=1", q2, co2, zero2, RV2);
    end
    rst_n = 1'b1;
    drive(0, 0, 1, LOAD, 8'h3C, 0);
    vectors++;
    if ({q, co, zero} !== {8'h3C, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL load_before_reset: q=%h co=%b zero=%b expected q=3c co=0 zero=0", q, co, zero);
    end
    rst_n = 1'b0;
    #2;
    vectors++;
    if ({q, co, zero} !== {RV8, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL async_reset: q=%h co=%b zero=%b expected q=%h co=0 zero=0", q, co, zero, RV8);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(0, 0, 1, HOLD, 8'h00, 0);
    vectors++;
    if ({q, co, zero} !== {RV8, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL hold_after_reset: q=%h co=%b zero=%b expected q=%h co=0 zero=0", q, co, zero, RV8);
    end
  endtask

  task automatic test_load_shift();
    op_t        ops[5];
    logic [7:0] ds[5];
    logic       sins[5];
    logic [7:0] eq[5];
    logic       eco[5];
    ops  = '{LOAD, SHL, SHR, ROR, ROL};
    ds   = '{8'h81, 8'h00, 8'h00, 8'h00, 8'h00};
    sins = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    eq   = '{8'h81, 8'h02, 8'h81, 8'hC0, 8'h81};
    eco  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, ops[i], ds[i], sins[i]);
      vectors++;
      if ({q, co, zero} !== {eq[i], eco[i], 1'b0}) begin
        miscompares++;
        $display("FAIL load_shift[%0d]: q=%h co=%b zero=%b expected q=%h co=%b zero=0",
                 i, q, co, zero, eq[i], eco[i]);
      end
    end
  endtask

  task automatic test_count_wrap();
    op_t        ops[4];
    logic [7:0] eq[4];
    logic       eco[4];
    logic       ez[4];
    ops = '{LOAD, INC, DEC, DEC};
    eq  = '{8'hFF, 8'h00, 8'hFF, 8'hFE};
    eco = '{1'b0, 1'b1, 1'b1, 1'b0};
    ez  = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, ops[i], 8'hFF, 0);
      vectors++;
      if ({q, co, zero} !== {eq[i], eco[i], ez[i]}) begin
        miscompares++;
        $display("FAIL count_wrap[%0d]: q=%h co=%b zero=%b expected q=%h co=%b zero=%b",
                 i, q, co, zero, eq[i], eco[i], ez[i]);
      end
    end
  endtask

  task automatic test_priority();
    logic       cs[8];
    logic       ss[8];
    logic       es[8];
    op_t        ops[8];
    logic [7:0] eq[8];
    logic       eco[8];
    cs  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    ss  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    es  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    ops = '{LOAD, LOAD, LOAD, DEC, INC, INC, INC, INC};
    eq  = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
    eco = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      drive(cs[i], ss[i], es[i], ops[i], (i == 2) ? 8'h00 : 8'h55, 0);
      vectors++;
      if ({q, co, zero} !== {eq[i], eco[i], (eq[i] == 8'h00)}) begin
        miscompares++;
        $display("FAIL priority[%0d]: q=%h co=%b zero=%b expected q=%h co=%b zero=%b",
                 i, q, co, zero, eq[i], eco[i], (eq[i] == 8'h00));
      end
    end
  endtask

  task automatic test_reset_mid_count();
    logic [7:0] exp_q;
    for (int i = 1; i <= 3; i++) begin
      drive(0, 0, 1, INC, 8'h00, 0);
      vectors++;
      if ({q, co} !== {8'(i), 1'b0}) begin
        miscompares++;
        $display("FAIL mid_count_inc[%0d]: q=%h co=%b expected q=%h co=0", i, q, co, 8'(i));
      end
    end
    rst_n = 1'b0;
    #2;
    vectors++;
    if ({q, co, zero} !== {RV8, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL mid_count_reset: q=%h co=%b zero=%b expected q=%h co=0 zero=0", q, co, zero, RV8);
    end
    @(posedge clk); #1;
    vectors++;
    if (q !== RV8) begin
      miscompares++;
      $display("FAIL mid_count_held: q=%h expected q=%h", q, RV8);
    end
    rst_n = 1'b1;
    exp_q = RV8;
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1, INC, 8'h00, 0);
      exp_q = exp_q + 8'd1;
      vectors++;
      if ({q, co} !== {exp_q, 1'b0}) begin
        miscompares++;
        $display("FAIL mid_count_resume[%0d]: q=%h co=%b expected q=%h co=0", i, q, co, exp_q);
      end
    end
  endtask

  task automatic test_random(input int cycles);
    int mq8, mq2;
    bit mc8, mc2;
    bit r8, r2;
    rst_n = 1'b0; rst2_n = 1'b0;
    @(posedge clk); #1;
    mq8 = int'(RV8); mc8 = 0;
    mq2 = int'(RV2); mc2 = 0;
    for (int i = 0; i < cycles; i++) begin
      r8 = ($urandom_range(0, 199) == 0);
      r2 = ($urandom_range(0, 199) == 0);
      rst_n  = ~r8;
      rst2_n = ~r2;
      clr  = ($urandom_range(0, 15) == 0);
      set  = ($urandom_range(0, 15) == 0);
      en   = ($urandom_range(0, 7) != 0);
      op   = op_t'($urandom_range(0, 7));
      d    = 8'($urandom);
      sin  = 1'($urandom);
      clr2 = ($urandom_range(0, 15) == 0);
      set2 = ($urandom_range(0, 15) == 0);
      en2  = ($urandom_range(0, 7) != 0);
      op2  = op_t'($urandom_range(0, 7));
      d2   = 2'($urandom);
      sin2 = 1'($urandom);
      if (r8) begin
        mq8 = int'(RV8); mc8 = 0;
      end else begin
        model_step(8, clr, set, en, int'(op), int'(d), sin, mq8, mc8);
      end
      if (r2) begin
        mq2 = int'(RV2); mc2 = 0;
      end else begin
        model_step(2, clr2, set2, en2, int'(op2), int'(d2), sin2, mq2, mc2);
      end
      @(posedge clk); #1;
      vectors++;
      if ({q, co, zero} !== {8'(mq8), mc8, (mq8 == 0)}) begin
        miscompares++;
        $display("FAIL random8[%0d]: q=%h co=%b zero=%b expected q=%h co=%b zero=%b",
                 i, q, co, zero, 8'(mq8), mc8, (mq8 == 0));
      end
      vectors++;
      if ({q2, co2, zero2} !== {2'(mq2), mc2, (mq2 == 0)}) begin
        miscompares++;
        $display("FAIL random2[%0d]: q=%b co=%b zero=%b expected q=%b co=%b zero=%b",
                 i, q2, co2, zero2, 2'(mq2), mc2, (mq2 == 0));
      end
    end
    rst_n = 1'b1; rst2_n = 1'b1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_load_shift();
    test_count_wrap();
    test_priority();
    test_reset_mid_count();
    test_random(10000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
